mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned STRB_W           = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    // Request fields latched at grant and presented on the shared memory port
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data-stage ports onto one memory port.
// Data wins by default; a saturating counter hands fetch the port once data
// has been granted STARVE_LIMIT times in a row while fetch was waiting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req_arb_i,
    input  logic [ADDR_W-1:0] i_addr_arb_i,
    output logic              i_ack_arb_o,
    output logic [DATA_W-1:0] i_rdata_arb_o,

    input  logic              d_req_arb_i,
    input  logic              d_wr_arb_i,
    input  logic [ADDR_W-1:0] d_addr_arb_i,
    input  logic [DATA_W-1:0] d_wdata_arb_i,
    input  logic [STRB_W-1:0] d_strb_arb_i,
    output logic              d_ack_arb_o,
    output logic [DATA_W-1:0] d_rdata_arb_o,

    output logic              mem_req_arb_o,
    output logic              mem_wr_arb_o,
    output logic [ADDR_W-1:0] mem_addr_arb_o,
    output logic [DATA_W-1:0] mem_wdata_arb_o,
    output logic [STRB_W-1:0] mem_strb_arb_o,
    input  logic              mem_ack_arb_i,
    input  logic [DATA_W-1:0] mem_rdata_arb_i,

    output logic              stall_fetch_arb_o,
    output logic              stall_mem_arb_o
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    mem_cmd_t          r_cmd;
    mem_cmd_t          w_cmd_nxt;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_mem_req;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_turnaround;
    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_starved;
    logic              w_i_done;
    logic              w_d_done;

    // No grant in a completion cycle: the acked owner cannot be re-granted and
    // holding off the other side too keeps the D-over-I priority deterministic.
    assign w_turnaround = r_i_ack | r_d_ack;
    assign w_i_pend     = i_req_arb_i & ~w_turnaround;
    assign w_d_pend     = d_req_arb_i & ~w_turnaround;
    assign w_starved    = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Next-state, grant selection and starvation counter update
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_starve_cnt;
        w_i_done    = 1'b0;
        w_d_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_pend && !(w_i_pend && w_starved)) begin
                    w_state_nxt = ST_BUSY_D;
                    w_cmd_nxt   = '{wr: d_wr_arb_i, addr: d_addr_arb_i,
                                    wdata: d_wdata_arb_i, strb: d_strb_arb_i};
                    if (i_req_arb_i && !w_starved) begin
                        w_cnt_nxt = r_starve_cnt + CNT_W'(1);
                    end
                end else if (w_i_pend) begin
                    w_state_nxt = ST_BUSY_I;
                    w_cmd_nxt   = '{wr: 1'b0, addr: i_addr_arb_i,
                                    wdata: '0, strb: '0};
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY_I: begin
                if (mem_ack_arb_i) begin
                    w_state_nxt = ST_IDLE;
                    w_i_done    = 1'b1;
                end
            end
            ST_BUSY_D: begin
                if (mem_ack_arb_i) begin
                    w_state_nxt = ST_IDLE;
                    w_d_done    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched command, counter and memory request register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_starve_cnt <= w_cnt_nxt;
            r_mem_req    <= (w_state_nxt != ST_IDLE);
        end
    end

    // Completion pulses and read-data capture for the owning requester
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= w_i_done;
            r_d_ack <= w_d_done;
            if (w_i_done) begin
                r_i_rdata <= mem_rdata_arb_i;
            end
            if (w_d_done && !r_cmd.wr) begin
                r_d_rdata <= mem_rdata_arb_i;
            end
        end
    end

    assign i_ack_arb_o       = r_i_ack;
    assign i_rdata_arb_o     = r_i_rdata;
    assign d_ack_arb_o       = r_d_ack;
    assign d_rdata_arb_o     = r_d_rdata;
    assign mem_req_arb_o     = r_mem_req;
    assign mem_wr_arb_o      = r_cmd.wr;
    assign mem_addr_arb_o    = r_cmd.addr;
    assign mem_wdata_arb_o   = r_cmd.wdata;
    assign mem_strb_arb_o    = r_cmd.strb;
    assign stall_fetch_arb_o = i_req_arb_i & ~r_i_ack;
    assign stall_mem_arb_o   = d_req_arb_i & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written starvation and mid-transaction reset sequences.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_wr, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_strb;
    logic        i_ack, d_ack, mem_req, mem_wr, stall_f, stall_m;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_strb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_req_arb_i       (i_req),
        .i_addr_arb_i      (i_addr),
        .i_ack_arb_o       (i_ack),
        .i_rdata_arb_o     (i_rdata),
        .d_req_arb_i       (d_req),
        .d_wr_arb_i        (d_wr),
        .d_addr_arb_i      (d_addr),
        .d_wdata_arb_i     (d_wdata),
        .d_strb_arb_i      (d_strb),
        .d_ack_arb_o       (d_ack),
        .d_rdata_arb_o     (d_rdata),
        .mem_req_arb_o     (mem_req),
        .mem_wr_arb_o      (mem_wr),
        .mem_addr_arb_o    (mem_addr),
        .mem_wdata_arb_o   (mem_wdata),
        .mem_strb_arb_o    (mem_strb),
        .mem_ack_arb_i     (mem_ack),
        .mem_rdata_arb_i   (mem_rdata),
        .stall_fetch_arb_o (stall_f),
        .stall_mem_arb_o   (stall_m)
    );

    typedef struct {
        logic        ir;  logic [31:0] ia;
        logic        dr;  logic dw; logic [31:0] da; logic [31:0] dwd; logic [3:0] ds;
        logic        ma;  logic [31:0] mrd;
        logic        emr; logic emw; logic [31:0] ema; logic [31:0] ewd; logic [3:0] es;
        logic        eia; logic eda; logic esf; logic esm;
        logic [31:0] eir; logic [31:0] edr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da, logic [31:0] dwd,
        logic [3:0] ds, logic ma, logic [31:0] mrd, logic emr, logic emw, logic [31:0] ema,
        logic [31:0] ewd, logic [3:0] es, logic eia, logic eda, logic esf, logic esm,
        logic [31:0] eir, logic [31:0] edr);
        vec_t v;
        v.ir = ir;   v.ia = ia;   v.dr = dr;   v.dw = dw;   v.da = da;   v.dwd = dwd; v.ds = ds;
        v.ma = ma;   v.mrd = mrd;
        v.emr = emr; v.emw = emw; v.ema = ema; v.ewd = ewd; v.es = es;
        v.eia = eia; v.eda = eda; v.esf = esf; v.esm = esm; v.eir = eir; v.edr = edr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0;
        d_wdata = '0; d_strb = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Apply one table row for a full cycle and check the outputs of that cycle
    task automatic apply_row(input int idx);
        vec_t v;
        v = tbl[idx];
        @(negedge clk);
        i_req = v.ir; i_addr = v.ia; d_req = v.dr; d_wr = v.dw; d_addr = v.da;
        d_wdata = v.dwd; d_strb = v.ds; mem_ack = v.ma; mem_rdata = v.mrd;
        #1;
        chk("mem_req", idx, 32'(mem_req), 32'(v.emr));
        if (v.emr) begin
            chk("mem_wr",   idx, 32'(mem_wr), 32'(v.emw));
            chk("mem_addr", idx, mem_addr, v.ema);
        end
        if (v.emr && v.emw) begin
            chk("mem_wdata", idx, mem_wdata, v.ewd);
            chk("mem_strb",  idx, 32'(mem_strb), 32'(v.es));
        end
        chk("i_ack",   idx, 32'(i_ack),   32'(v.eia));
        chk("d_ack",   idx, 32'(d_ack),   32'(v.eda));
        chk("stall_f", idx, 32'(stall_f), 32'(v.esf));
        chk("stall_m", idx, 32'(stall_m), 32'(v.esm));
        chk("i_rdata", idx, i_rdata, v.eir);
        chk("d_rdata", idx, d_rdata, v.edr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_grants;
        int i_seen;
        int d_after;
        int reached;

        // Fetch read of 0x100, memory acks in cycle 4, i_ack in cycle 5
        tbl.push_back(mk(1,32'h100,0,0,0,0,0, 0,0,          0,0,0,0,0, 0,0,1,0, 0,0));
        tbl.push_back(mk(1,32'h100,0,0,0,0,0, 0,0,          1,0,32'h100,0,0, 0,0,1,0, 0,0));
        tbl.push_back(mk(1,32'h100,0,0,0,0,0, 0,0,          1,0,32'h100,0,0, 0,0,1,0, 0,0));
        tbl.push_back(mk(1,32'h100,0,0,0,0,0, 0,0,          1,0,32'h100,0,0, 0,0,1,0, 0,0));
        tbl.push_back(mk(1,32'h100,0,0,0,0,0, 1,32'hCAFE0100, 1,0,32'h100,0,0, 0,0,1,0, 0,0));
        // req held through the ack cycle: no re-grant
        tbl.push_back(mk(1,32'h100,0,0,0,0,0, 0,0,          0,0,0,0,0, 1,0,0,0, 32'hCAFE0100,0));
        tbl.push_back(mk(1,32'h104,0,0,0,0,0, 0,0,          0,0,0,0,0, 0,0,1,0, 32'hCAFE0100,0));
        // minimum latency, req dropped mid-transaction
        tbl.push_back(mk(0,32'h104,0,0,0,0,0, 1,32'h11110104, 1,0,32'h104,0,0, 0,0,0,0, 32'hCAFE0100,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,                0,0,0,0,0, 1,0,0,0, 32'h11110104,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,                0,0,0,0,0, 0,0,0,0, 32'h11110104,0));
        // simultaneous I read and D write: D first, write data ignored on return
        tbl.push_back(mk(1,32'h300,1,1,32'h200,32'hDEADBEEF,4'hF, 0,0,            0,0,0,0,0, 0,0,1,1, 32'h11110104,0));
        tbl.push_back(mk(1,32'h300,1,1,32'h200,32'hDEADBEEF,4'hF, 1,32'h55555555, 1,1,32'h200,32'hDEADBEEF,4'hF, 0,0,1,1, 32'h11110104,0));
        tbl.push_back(mk(1,32'h300,0,0,0,0,0, 0,0,          0,0,0,0,0, 0,1,1,0, 32'h11110104,0));
        tbl.push_back(mk(1,32'h300,0,0,0,0,0, 0,0,          0,0,0,0,0, 0,0,1,0, 32'h11110104,0));
        tbl.push_back(mk(1,32'h300,0,0,0,0,0, 1,32'h00000300, 1,0,32'h300,0,0, 0,0,1,0, 32'h11110104,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,                0,0,0,0,0, 1,0,0,0, 32'h300,0));
        // zero-strobe write passes through unchanged
        tbl.push_back(mk(0,0,1,1,32'h204,32'h12345678,4'h0, 0,0,            0,0,0,0,0, 0,0,0,1, 32'h300,0));
        tbl.push_back(mk(0,0,1,1,32'h204,32'h12345678,4'h0, 1,32'h77777777, 1,1,32'h204,32'h12345678,4'h0, 0,0,0,1, 32'h300,0));
        tbl.push_back(mk(0,0,1,1,32'h204,32'h12345678,4'h0, 0,0,            0,0,0,0,0, 0,1,0,0, 32'h300,0));
        // D read after the ack cycle
        tbl.push_back(mk(0,0,1,0,32'h208,0,0, 0,0,          0,0,0,0,0, 0,0,0,1, 32'h300,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,32'hA5A50208,     1,0,32'h208,0,0, 0,0,0,0, 32'h300,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,                0,0,0,0,0, 0,1,0,0, 32'h300,32'hA5A50208));
        // stray memory acks in IDLE are ignored
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,32'hFFFFFFFF,     0,0,0,0,0, 0,0,0,0, 32'h300,32'hA5A50208));
        tbl.push_back(mk(0,0,0,0,0,0,0, 1,32'hFFFFFFFF,     0,0,0,0,0, 0,0,0,0, 32'h300,32'hA5A50208));

        // Reset state
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mem_req",  0, 32'(mem_req), 32'h0);
        chk("rst_mem_wr",   0, 32'(mem_wr), 32'h0);
        chk("rst_mem_addr", 0, mem_addr, 32'h0);
        chk("rst_i_ack",    0, 32'(i_ack), 32'h0);
        chk("rst_d_ack",    0, 32'(d_ack), 32'h0);
        chk("rst_i_rdata",  0, i_rdata, 32'h0);
        chk("rst_d_rdata",  0, d_rdata, 32'h0);
        chk("rst_state",    0, 32'(dut.r_state), 32'(ST_IDLE));
        chk("rst_cnt",      0, 32'(dut.r_starve_cnt), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_row(i);
        end

        // Starvation: D requests continuously with I pending, memory acks at once
        @(negedge clk);
        idle_inputs();
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h500;
        d_grants = 0; i_seen = 0; d_after = 0;
        for (int c = 0; c < 60 && d_after == 0; c++) begin
            @(negedge clk);
            mem_ack = mem_req;
            if (mem_req) begin
                if (mem_addr == 32'h400) begin
                    i_seen = 1;
                    chk("starve_cnt_clear", c, 32'(dut.r_starve_cnt), 32'h0);
                end else if (i_seen != 0) begin
                    d_after = 1;
                end else begin
                    d_grants++;
                    if (d_grants == 4) chk("starve_cnt_sat", c, 32'(dut.r_starve_cnt), 32'h4);
                end
            end
        end
        chk("starve_d_grants", 0, 32'(d_grants), 32'h4);
        chk("starve_i_grant",  0, 32'(i_seen), 32'h1);
        chk("starve_d_after",  0, 32'(d_after), 32'h1);
        i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ack = mem_req;
        end
        mem_ack = 1'b0;

        // Reset during BUSY_D, then a stale memory ack after release
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h600; d_wdata = 32'h66; d_strb = 4'h3;
        reached = 0;
        for (int c = 0; c < 10 && reached == 0; c++) begin
            @(negedge clk);
            if (mem_req) reached = 1;
        end
        chk("rst_busy_reached", 0, 32'(reached), 32'h1);
        chk("rst_busy_state",   0, 32'(dut.r_state), 32'(ST_BUSY_D));
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_req", 0, 32'(mem_req), 32'h0);
        chk("rst_mid_d_ack",   0, 32'(d_ack), 32'h0);
        @(negedge clk);
        d_req = 1'b0;
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h00000BAD;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("stale_d_ack",   c, 32'(d_ack), 32'h0);
            chk("stale_mem_req", c, 32'(mem_req), 32'h0);
            chk("stale_d_rdata", c, d_rdata, 32'h0);
            chk("stale_state",   c, 32'(dut.r_state), 32'(ST_IDLE));
        end
        mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
